// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle main controller and its ALU decoder.
package ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_PASSB = 3'b100,
        ALU_SLT   = 3'b101
    } alu_op_t;

    // Which decode rule the ALU decoder applies in the current state
    typedef enum logic [1:0] {
        CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_ITYPE
    } alu_class_t;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_REG   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;
    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUControl decode from opcode, funct and the controller's state class.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  alu_class_t         cls,
    output logic [ALUC_W-1:0]  alu_control,
    output logic               funct_valid
);

    always_comb begin
        alu_control = ALU_ADD;
        funct_valid = 1'b1;
        case (cls)
            CLS_SUB:   alu_control = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    F_ADD:   alu_control = ALU_ADD;
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: funct_valid = 1'b0;
                endcase
            end
            // lui relies on the datapath presenting imm<<16 on the B input
            CLS_ITYPE: if (op == OP_LUI) alu_control = ALU_PASSB;
            default:   alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller: per-instruction FSM driving datapath selects and write enables.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               mem_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic [SEL_W-1:0]   alu_src_a,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   result_src,
    output logic [ALUC_W-1:0]  alu_control,
    output logic               illegal
);

    state_t     state, state_next;
    state_t     illegal_target;
    alu_class_t alu_cls;
    logic       funct_valid;
    logic       illegal_q;

    assign illegal_target = ILLEGAL_HALT ? HALT : FETCH;
    assign illegal        = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == HALT) illegal_q <= 1'b1;
        end
    end

    // Kept apart from the main decode so funct_valid never loops back into its own block
    always_comb begin
        alu_cls = CLS_ADD;
        case (state)
            EXECR:   alu_cls = CLS_RTYPE;
            EXECI:   alu_cls = CLS_ITYPE;
            BRANCH:  alu_cls = CLS_SUB;
            default: alu_cls = CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct       (funct),
        .cls         (alu_cls),
        .alu_control (alu_control),
        .funct_valid (funct_valid)
    );

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW:    state_next = MEMADR;
                    OP_RTYPE:        state_next = EXECR;
                    OP_ADDI, OP_LUI: state_next = EXECI;
                    OP_BEQ:          state_next = BRANCH;
                    OP_J:            state_next = JUMP;
                    default:         state_next = illegal_target;
                endcase
            end
            MEMADR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = mem_ready;
                if (mem_ready) state_next = FETCH;
            end
            EXECR: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_REG;
                state_next = funct_valid ? ALUWB : illegal_target;
            end
            EXECI: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_IMM;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = (op == OP_RTYPE);
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = SRCA_REG;
                alu_src_b  = SRCB_REG;
                pc_write   = zero;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = 1'b1;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
        // Enables follow rst_n directly so no partial write can slip out during reset
        if (!rst_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors, checked at the falling edge.
module tb_multicycle_ctrl;

    localparam int unsigned VW = 18;

    typedef struct {
        string         nm;
        logic [VW-1:0] e0;
        logic [VW-1:0] e1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    logic       mem_req0, adr_src0, ir_write0, pc_write0, pc_src0, mem_write0, reg_write0, reg_dst0, illegal0;
    logic [1:0] alu_src_a0, alu_src_b0, result_src0;
    logic [2:0] alu_control0;
    logic       mem_req1, adr_src1, ir_write1, pc_write1, pc_src1, mem_write1, reg_write1, reg_dst1, illegal1;
    logic [1:0] alu_src_a1, alu_src_b1, result_src1;
    logic [2:0] alu_control1;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req0), .adr_src(adr_src0), .ir_write(ir_write0), .pc_write(pc_write0),
        .pc_src(pc_src0), .mem_write(mem_write0), .reg_write(reg_write0), .reg_dst(reg_dst0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .result_src(result_src0),
        .alu_control(alu_control0), .illegal(illegal0)
    );

    multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) u_dut_nop (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req1), .adr_src(adr_src1), .ir_write(ir_write1), .pc_write(pc_write1),
        .pc_src(pc_src1), .mem_write(mem_write1), .reg_write(reg_write1), .reg_dst(reg_dst1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .result_src(result_src1),
        .alu_control(alu_control1), .illegal(illegal1)
    );

    wire [VW-1:0] vec0 = {mem_req0, adr_src0, ir_write0, pc_write0, pc_src0, mem_write0, reg_write0,
                          reg_dst0, alu_src_a0, alu_src_b0, result_src0, alu_control0, illegal0};
    wire [VW-1:0] vec1 = {mem_req1, adr_src1, ir_write1, pc_write1, pc_src1, mem_write1, reg_write1,
                          reg_dst1, alu_src_a1, alu_src_b1, result_src1, alu_control1, illegal1};

    // Field order: mem_req adr_src ir_write pc_write pc_src mem_write reg_write reg_dst a b res aluc illegal
    function automatic logic [VW-1:0] v(input logic mr, as, irw, pcw, pcs, mw, rw, rd,
                                        input logic [1:0] a, b, rs, input logic [2:0] ac, input logic il);
        return {mr, as, irw, pcw, pcs, mw, rw, rd, a, b, rs, ac, il};
    endfunction

    function automatic logic [VW-1:0] e_fetch(input logic go);
        return v(1, 0, go, go, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_decode();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_memadr();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_memread();
        return v(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_memwb();
        return v(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_memwrite(input logic go);
        return v(1, 1, 0, 0, 0, go, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_execr(input logic [2:0] ac);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, ac, 0);
    endfunction
    function automatic logic [VW-1:0] e_execi(input logic [2:0] ac);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ac, 0);
    endfunction
    function automatic logic [VW-1:0] e_aluwb(input logic rd);
        return v(0, 0, 0, 0, 0, 0, 1, rd, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_branch(input logic z);
        return v(0, 0, 0, z, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 0);
    endfunction
    function automatic logic [VW-1:0] e_jump();
        return v(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [VW-1:0] e_halt();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what both DUTs must show
    task automatic step(input string nm, input logic r, input logic [5:0] o, f,
                        input logic z, mr, input logic [VW-1:0] e0, e1);
        exp_t e;
        rst_n     = r;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = mr;
        e.nm = nm;
        e.e0 = e0;
        e.e1 = e1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (vec0 !== e.e0) begin
                errors++;
                $display("FAIL %s halt_dut got %b want %b", e.nm, vec0, e.e0);
            end
            checks++;
            if (vec1 !== e.e1) begin
                errors++;
                $display("FAIL %s nop_dut got %b want %b", e.nm, vec1, e.e1);
            end
        end
    end

    logic [5:0] r_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] r_ac    [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    logic [5:0] i_op    [2] = '{6'b001000, 6'b001111};
    logic [2:0] i_ac    [2] = '{3'b000, 3'b100};

    initial begin
        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held 3 cycles with mem_ready=1: FETCH decode, enables forced low
        for (int i = 0; i < 3; i++) step("reset", 0, 6'd0, 6'd0, 0, 1, e_fetch(0), e_fetch(0));

        for (int i = 0; i < 5; i++) begin
            step("r_fetch",  1, 6'b000000, r_funct[i], 0, 1, e_fetch(1), e_fetch(1));
            step("r_decode", 1, 6'b000000, r_funct[i], 0, 1, e_decode(), e_decode());
            step("r_exec",   1, 6'b000000, r_funct[i], 0, 1, e_execr(r_ac[i]), e_execr(r_ac[i]));
            step("r_wb",     1, 6'b000000, r_funct[i], 0, 1, e_aluwb(1), e_aluwb(1));
        end

        for (int i = 0; i < 2; i++) begin
            step("i_fetch",  1, i_op[i], 6'd0, 0, 1, e_fetch(1), e_fetch(1));
            step("i_decode", 1, i_op[i], 6'd0, 0, 1, e_decode(), e_decode());
            step("i_exec",   1, i_op[i], 6'd0, 0, 1, e_execi(i_ac[i]), e_execi(i_ac[i]));
            step("i_wb",     1, i_op[i], 6'd0, 0, 1, e_aluwb(0), e_aluwb(0));
        end

        // lw with two wait cycles in MEMREAD
        step("lw_fetch",  1, 6'b100011, 6'd0, 0, 1, e_fetch(1), e_fetch(1));
        step("lw_decode", 1, 6'b100011, 6'd0, 0, 1, e_decode(), e_decode());
        step("lw_adr",    1, 6'b100011, 6'd0, 0, 1, e_memadr(), e_memadr());
        step("lw_wait",   1, 6'b100011, 6'd0, 0, 0, e_memread(), e_memread());
        step("lw_wait",   1, 6'b100011, 6'd0, 0, 0, e_memread(), e_memread());
        step("lw_read",   1, 6'b100011, 6'd0, 0, 1, e_memread(), e_memread());
        step("lw_wb",     1, 6'b100011, 6'd0, 0, 1, e_memwb(), e_memwb());

        // sw with one wait cycle in FETCH
        step("sw_fwait",  1, 6'b101011, 6'd0, 0, 0, e_fetch(0), e_fetch(0));
        step("sw_fetch",  1, 6'b101011, 6'd0, 0, 1, e_fetch(1), e_fetch(1));
        step("sw_decode", 1, 6'b101011, 6'd0, 0, 1, e_decode(), e_decode());
        step("sw_adr",    1, 6'b101011, 6'd0, 0, 1, e_memadr(), e_memadr());
        step("sw_write",  1, 6'b101011, 6'd0, 0, 1, e_memwrite(1), e_memwrite(1));

        for (int z = 1; z >= 0; z--) begin
            step("beq_fetch",  1, 6'b000100, 6'd0, 1'(z), 1, e_fetch(1), e_fetch(1));
            step("beq_decode", 1, 6'b000100, 6'd0, 1'(z), 1, e_decode(), e_decode());
            step("beq_branch", 1, 6'b000100, 6'd0, 1'(z), 1, e_branch(1'(z)), e_branch(1'(z)));
        end

        step("j_fetch",  1, 6'b000010, 6'd0, 0, 1, e_fetch(1), e_fetch(1));
        step("j_decode", 1, 6'b000010, 6'd0, 0, 1, e_decode(), e_decode());
        step("j_jump",   1, 6'b000010, 6'd0, 0, 1, e_jump(), e_jump());

        // Illegal opcode: sticky HALT vs. return to FETCH
        step("badop_fetch",  1, 6'b111111, 6'd0, 0, 1, e_fetch(1), e_fetch(1));
        step("badop_decode", 1, 6'b111111, 6'd0, 0, 1, e_decode(), e_decode());
        step("badop_halt",   1, 6'b111111, 6'd0, 0, 0, e_halt(), e_fetch(0));
        step("badop_sticky", 1, 6'b000000, 6'b100000, 0, 1, e_halt(), e_fetch(1));
        step("badop_reset",  0, 6'd0, 6'd0, 0, 0, e_fetch(0), e_fetch(0));

        // Illegal funct
        step("badfn_fetch",  1, 6'b000000, 6'b111111, 0, 1, e_fetch(1), e_fetch(1));
        step("badfn_decode", 1, 6'b000000, 6'b111111, 0, 1, e_decode(), e_decode());
        step("badfn_exec",   1, 6'b000000, 6'b111111, 0, 1, e_execr(3'b000), e_execr(3'b000));
        step("badfn_halt",   1, 6'b000000, 6'b111111, 0, 0, e_halt(), e_fetch(0));
        step("badfn_reset",  0, 6'd0, 6'd0, 0, 0, e_fetch(0), e_fetch(0));

        // Reset asserted in MEMWRITE together with mem_ready: store strobe must not appear
        step("rstw_fetch",  1, 6'b101011, 6'd0, 0, 1, e_fetch(1), e_fetch(1));
        step("rstw_decode", 1, 6'b101011, 6'd0, 0, 1, e_decode(), e_decode());
        step("rstw_adr",    1, 6'b101011, 6'd0, 0, 1, e_memadr(), e_memadr());
        step("rstw_wait",   1, 6'b101011, 6'd0, 0, 0, e_memwrite(0), e_memwrite(0));
        step("rstw_reset",  0, 6'b101011, 6'd0, 0, 1, e_fetch(0), e_fetch(0));
        step("rstw_refetch", 1, 6'b101011, 6'd0, 0, 1, e_fetch(1), e_fetch(1));
        step("rstw_decode2", 1, 6'b101011, 6'd0, 0, 1, e_decode(), e_decode());

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
